// File: rtl/ddr_pkg.sv
// DDR4 command encoding shared by the init-path blocks.
// Holds the DES/MRS/ZQCL command enum, the RAS_n/CAS_n/WE_n patterns,
// the tMRD/tMOD timing constants, the pin payload struct and the pin encoder.
package ddr_pkg;

    localparam int unsigned tMRD    = 8;
    localparam int unsigned tMOD    = 24;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned BG_W    = 2;
    localparam int unsigned BA_W    = 2;
    localparam int unsigned MR_AW   = 3;
    localparam int unsigned MODE_W  = 22;
    localparam int unsigned MR_NUM  = 7;
    localparam int unsigned GAP_W   = $clog2(tMOD + 1);

    // {RAS_n, CAS_n, WE_n} carried on A[16:14]
    localparam logic [2:0] RWC_DES  = 3'b111;
    localparam logic [2:0] RWC_MRS  = 3'b000;
    localparam logic [2:0] RWC_ZQCL = 3'b110;

    typedef enum logic [1:0] {
        CMD_DES  = 2'd0,
        CMD_MRS  = 2'd1,
        CMD_ZQCL = 2'd2
    } ddr_cmd_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_DONE = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic              cs_n;
        logic              act_n;
        logic [BG_W-1:0]   bg;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } ddr_pins_t;

    // Pin image for one command; MRS opcode[16:14] is overwritten by the command bits.
    function automatic ddr_pins_t encode_cmd(input ddr_cmd_e          cmd,
                                             input logic [MR_AW-1:0]  mr_addr,
                                             input logic [ADDR_W-1:0] opcode);
        ddr_pins_t p;
        p.cs_n        = 1'b1;
        p.act_n       = 1'b1;
        p.bg          = '0;
        p.ba          = '0;
        p.addr        = '0;
        p.addr[16:14] = RWC_DES;
        case (cmd)
            CMD_MRS: begin
                p.cs_n        = 1'b0;
                p.bg          = {1'b0, mr_addr[2]};
                p.ba          = mr_addr[1:0];
                p.addr        = opcode;
                p.addr[16:14] = RWC_MRS;
            end
            CMD_ZQCL: begin
                p.cs_n        = 1'b0;
                p.addr[16:14] = RWC_ZQCL;
                p.addr[10]    = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cmd_encoder_if.sv
// Command path between the init controller and the command encoder.
// master: init controller (drives strobes, mode_reg, ini_done; sees pins).
// slave : cmd_encoder (receives strobes, drives the DDR4 command pins).
interface cmd_encoder_if;

    logic                              des_rdy;
    logic                              mrs_rdy;
    logic                              zqcl_rdy;
    logic [ddr_pkg::MODE_W-1:0]        mode_reg;
    logic                              ini_done;

    logic                              cs_n;
    logic                              act_n;
    logic [ddr_pkg::BG_W-1:0]          bg;
    logic [ddr_pkg::BA_W-1:0]          ba;
    logic [ddr_pkg::ADDR_W-1:0]        addr;

    modport master (
        output des_rdy, mrs_rdy, zqcl_rdy, mode_reg, ini_done,
        input  cs_n, act_n, bg, ba, addr
    );

    modport slave (
        input  des_rdy, mrs_rdy, zqcl_rdy, mode_reg, ini_done,
        output cs_n, act_n, bg, ba, addr
    );

endinterface

// File: rtl/cmd_encoder_mr_shadow.sv
// mr_shadow: shadow copies of MR0..MR6 plus a written bit per register.
// Ports: clk, reset (sync, active-high), we/wr_addr/wr_data write port,
//        mr (seven 18-bit registers), written (one bit per register).
module mr_shadow
    import ddr_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [MR_AW-1:0]               wr_addr,
    input  logic [ADDR_W-1:0]              wr_data,
    output logic [MR_NUM-1:0][ADDR_W-1:0]  mr,
    output logic [MR_NUM-1:0]              written
);

    // Address 7 matches no register, so it never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mr      <= '0;
            written <= '0;
        end else begin
            for (int unsigned i = 0; i < MR_NUM; i++) begin
                if (we && (wr_addr == MR_AW'(i))) begin
                    mr[i]      <= wr_data;
                    written[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cmd_encoder.sv
// cmd_encoder: turns init-controller strobes into registered DDR4 DES/MRS/ZQCL
// pin images, shadows MR0..MR6, checks MRS/ZQCL spacing and freezes the
// configuration once initialization is done.
// Ports: CK_t, reset (sync, active-high); bus (slave: strobes, mode_reg,
//        ini_done in; cs_n/act_n/bg/ba/addr out); cfg_* decoded MR fields;
//        cfg_valid; sticky cmd_err / timing_err / cfg_err.
module cmd_encoder
    import ddr_pkg::*;
(
    input  logic         CK_t,
    input  logic         reset,
    cmd_encoder_if.slave bus,
    output logic [3:0]   cfg_cl,
    output logic [1:0]   cfg_bl,
    output logic [1:0]   cfg_al,
    output logic [2:0]   cfg_cwl,
    output logic [2:0]   cfg_tccd,
    output logic         cfg_wr_pre,
    output logic         cfg_rd_pre,
    output logic         cfg_valid,
    output logic         cmd_err,
    output logic         timing_err,
    output logic         cfg_err
);

    logic [MR_NUM-1:0][ADDR_W-1:0] mr;
    logic [MR_NUM-1:0]             mr_written;

    ddr_pins_t         pins_q;
    enc_state_e        state_q;
    logic [GAP_W-1:0]  gap_q;

    ddr_cmd_e          cmd_c;
    logic              multi_c;
    logic              strobe_c;
    logic              mrs_bad_c;
    logic              issue_mrs_c;
    logic              issue_zq_c;
    logic              cmd_err_c;
    logic              timing_err_c;

    // Command selection (mrs > zqcl > des) and error detection for this cycle.
    always_comb begin
        cmd_c        = CMD_DES;
        multi_c      = (bus.des_rdy & bus.mrs_rdy) | (bus.des_rdy & bus.zqcl_rdy) |
                       (bus.mrs_rdy & bus.zqcl_rdy);
        strobe_c     = bus.des_rdy | bus.mrs_rdy | bus.zqcl_rdy;
        mrs_bad_c    = bus.mode_reg[21] | (|bus.mode_reg[16:14]) |
                       (bus.mode_reg[20:18] == 3'd7);
        if (state_q == ST_INIT) begin
            if (bus.mrs_rdy) begin
                if (!mrs_bad_c) begin
                    cmd_c = CMD_MRS;
                end
            end else if (bus.zqcl_rdy) begin
                cmd_c = CMD_ZQCL;
            end
        end
        issue_mrs_c  = (cmd_c == CMD_MRS);
        issue_zq_c   = (cmd_c == CMD_ZQCL);
        cmd_err_c    = multi_c | (bus.mrs_rdy & mrs_bad_c) |
                       ((state_q == ST_DONE) & strobe_c);
        timing_err_c = (issue_mrs_c & (gap_q < GAP_W'(tMRD))) |
                       (issue_zq_c  & (gap_q < GAP_W'(tMOD)));
    end

    // Pins, gap counter, sticky errors and INIT/DONE state.
    always_ff @(posedge CK_t) begin
        if (reset) begin
            pins_q     <= encode_cmd(CMD_DES, '0, '0);
            gap_q      <= GAP_W'(tMOD);
            state_q    <= ST_INIT;
            cfg_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            timing_err <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            pins_q     <= encode_cmd(cmd_c, bus.mode_reg[20:18], bus.mode_reg[17:0]);
            // gap_q holds "cycles since the last MRS" as seen by the next strobe
            if (issue_mrs_c) begin
                gap_q <= GAP_W'(1);
            end else if (gap_q < GAP_W'(tMOD)) begin
                gap_q <= gap_q + GAP_W'(1);
            end
            cmd_err    <= cmd_err | cmd_err_c;
            timing_err <= timing_err | timing_err_c;
            case (state_q)
                ST_INIT: begin
                    if (bus.ini_done) begin
                        state_q   <= ST_DONE;
                        cfg_valid <= 1'b1;
                        if (!(&mr_written)) begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DONE;
            endcase
        end
    end

    mr_shadow u_shadow (
        .clk     (CK_t),
        .reset   (reset),
        .we      (issue_mrs_c),
        .wr_addr (bus.mode_reg[20:18]),
        .wr_data (bus.mode_reg[17:0]),
        .mr      (mr),
        .written (mr_written)
    );

    assign bus.cs_n  = pins_q.cs_n;
    assign bus.act_n = pins_q.act_n;
    assign bus.bg    = pins_q.bg;
    assign bus.ba    = pins_q.ba;
    assign bus.addr  = pins_q.addr;

    assign cfg_cl     = {mr[0][6:4], mr[0][2]};
    assign cfg_bl     = mr[0][1:0];
    assign cfg_al     = mr[1][4:3];
    assign cfg_cwl    = mr[2][5:3];
    assign cfg_tccd   = mr[6][12:10];
    assign cfg_wr_pre = mr[4][12];
    assign cfg_rd_pre = mr[4][11];

    // Shadow fields that have no cfg output are still held for readback/debug.
    logic unused_shadow;
    assign unused_shadow = ^mr;

endmodule

// File: tb/tb_cmd_encoder.sv
// Directed bench for cmd_encoder: pin images go through a scoreboard queue,
// flags and configuration fields are checked against constants.
module tb_cmd_encoder;

    localparam int unsigned TMRD = ddr_pkg::tMRD;
    localparam int unsigned TMOD = ddr_pkg::tMOD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cfg_cl;
    logic [1:0] cfg_bl;
    logic [1:0] cfg_al;
    logic [2:0] cfg_cwl;
    logic [2:0] cfg_tccd;
    logic       cfg_wr_pre;
    logic       cfg_rd_pre;
    logic       cfg_valid;
    logic       cmd_err;
    logic       timing_err;
    logic       cfg_err;

    int         checks = 0;
    int         errors = 0;
    bit         tb_done = 1'b0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    cmd_encoder_if bus();

    cmd_encoder dut (
        .CK_t       (clk),
        .reset      (reset),
        .bus        (bus),
        .cfg_cl     (cfg_cl),
        .cfg_bl     (cfg_bl),
        .cfg_al     (cfg_al),
        .cfg_cwl    (cfg_cwl),
        .cfg_tccd   (cfg_tccd),
        .cfg_wr_pre (cfg_wr_pre),
        .cfg_rd_pre (cfg_rd_pre),
        .cfg_valid  (cfg_valid),
        .cmd_err    (cmd_err),
        .timing_err (timing_err),
        .cfg_err    (cfg_err)
    );

    // Expected {cs_n, act_n, bg, ba, addr} for one cycle of stimulus.
    function automatic logic [23:0] exp_pins(input bit d, input bit m, input bit z,
                                             input logic [21:0] mr, input bit done);
        logic [23:0] des;
        des = {2'b11, 4'b0000, 1'b0, 3'b111, 14'h0};
        if (done) return des;
        if (m) begin
            if (mr[21] || (mr[16:14] != 3'b000) || (mr[20:18] == 3'd7)) return des;
            return {1'b0, 1'b1, 1'b0, mr[20], mr[19:18], mr[17], 3'b000, mr[13:0]};
        end
        if (z) return {2'b01, 4'b0000, 1'b0, 3'b110, 3'b000, 1'b1, 10'h0};
        if (d) return des;
        return des;
    endfunction

    function automatic logic [17:0] mr_val(input int a, input logic [17:0] op2);
        case (a)
            0:       return 18'h00056;
            1:       return 18'h00008;
            2:       return op2;
            3:       return 18'h00004;
            4:       return 18'h01800;
            5:       return 18'h20400;
            default: return 18'h00800;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pins_check();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pins observed=output expected=none_queued");
        end else begin
            e = exp_q.pop_front();
            check("pins", {8'h0, bus.cs_n, bus.act_n, bus.bg, bus.ba, bus.addr}, {8'h0, e});
        end
    endtask

    task automatic step(input bit d, input bit m, input bit z, input logic [21:0] mr, input bit ini);
        @(negedge clk);
        reset        = 1'b0;
        bus.des_rdy  = d;
        bus.mrs_rdy  = m;
        bus.zqcl_rdy = z;
        bus.mode_reg = mr;
        bus.ini_done = ini;
        exp_q.push_back(exp_pins(d, m, z, mr, tb_done));
        @(posedge clk);
        #1;
        pins_check();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 22'h0, 1'b0);
    endtask

    task automatic mrs(input logic [2:0] a, input logic [17:0] op);
        step(1'b0, 1'b1, 1'b0, {1'b0, a, op}, 1'b0);
    endtask

    task automatic zqcl();
        step(1'b0, 1'b0, 1'b1, 22'h0, 1'b0);
    endtask

    // Reset cycle; an optional MRS strobe in the same cycle must be ignored.
    task automatic do_reset(input bit with_strobe);
        @(negedge clk);
        reset        = 1'b1;
        bus.des_rdy  = 1'b0;
        bus.mrs_rdy  = with_strobe;
        bus.zqcl_rdy = 1'b0;
        bus.mode_reg = {1'b0, 3'd2, 18'h00001};
        bus.ini_done = 1'b0;
        exp_q.push_back({2'b11, 4'b0000, 1'b0, 3'b111, 14'h0});
        @(posedge clk);
        #1;
        pins_check();
        tb_done = 1'b0;
    endtask

    // MR3,6,5,4,2,1,0 spaced tMRD+1, ZQCL after tMOD, then ini_done.
    task automatic full_seq(input int skip, input logic [17:0] op2);
        int order[7];
        order = '{3, 6, 5, 4, 2, 1, 0};
        for (int i = 0; i < 7; i++) begin
            if (order[i] != skip) begin
                mrs(3'(order[i]), mr_val(order[i], op2));
                idle(int'(TMRD));
            end
        end
        idle(int'(TMOD));
        zqcl();
        check("cfg_valid_before_done", 32'(cfg_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 22'h0, 1'b1);
        tb_done = 1'b1;
        step(1'b0, 1'b0, 1'b0, 22'h0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.des_rdy  = 1'b0;
        bus.mrs_rdy  = 1'b0;
        bus.zqcl_rdy = 1'b0;
        bus.mode_reg = 22'h0;
        bus.ini_done = 1'b0;

        // Reset state
        do_reset(1'b0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_errs", {29'h0, cmd_err, timing_err, cfg_err}, 32'd0);

        // Single MRS to MR3 with zero opcode
        mrs(3'd3, 18'h0);
        check("mr3_shadow", 32'(dut.u_shadow.mr[3]), 32'd0);
        check("mr3_errs", {29'h0, cmd_err, timing_err, cfg_err}, 32'd0);

        // Full clean sequence
        do_reset(1'b0);
        full_seq(-1, 18'h00018);
        check("seq_errs", {29'h0, cmd_err, timing_err, cfg_err}, 32'd0);
        check("seq_cfg_valid", 32'(cfg_valid), 32'd1);
        check("seq_cl", 32'(cfg_cl), 32'hB);
        check("seq_bl", 32'(cfg_bl), 32'h2);
        check("seq_al", 32'(cfg_al), 32'h1);
        check("seq_cwl", 32'(cfg_cwl), 32'h3);
        check("seq_tccd", 32'(cfg_tccd), 32'h2);
        check("seq_pre", {30'h0, cfg_wr_pre, cfg_rd_pre}, 32'h3);

        // Strobe after DONE: DES on pins, cmd_err, shadow frozen
        mrs(3'd0, 18'h00000);
        check("done_cmd_err", 32'(cmd_err), 32'd1);
        check("done_mr0_frozen", 32'(dut.u_shadow.mr[0]), 32'h56);
        do_reset(1'b0);
        check("done_rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("done_rst_cmd_err", 32'(cmd_err), 32'd0);

        // MRS gap exactly tMRD is legal, ZQCL at tMOD-1 is not
        mrs(3'd0, 18'h00056);
        idle(int'(TMRD) - 1);
        mrs(3'd1, 18'h00008);
        check("gap_tmrd_ok", 32'(timing_err), 32'd0);
        idle(int'(TMOD) - 2);
        zqcl();
        check("zq_early_terr", 32'(timing_err), 32'd1);
        check("zq_early_cmd_err", 32'(cmd_err), 32'd0);

        // Two MRS two cycles apart
        do_reset(1'b0);
        mrs(3'd0, 18'h00056);
        idle(1);
        mrs(3'd1, 18'h00008);
        check("mrs_close_terr", 32'(timing_err), 32'd1);
        check("mrs_close_cmd_err", 32'(cmd_err), 32'd0);

        // mrs + zqcl together: MRS wins
        do_reset(1'b0);
        step(1'b0, 1'b1, 1'b1, {1'b0, 3'd1, 18'h00008}, 1'b0);
        check("mrs_zq_cmd_err", 32'(cmd_err), 32'd1);
        check("mrs_zq_terr", 32'(timing_err), 32'd0);

        // des + zqcl together: ZQCL wins
        do_reset(1'b0);
        step(1'b1, 1'b0, 1'b1, 22'h0, 1'b0);
        check("des_zq_cmd_err", 32'(cmd_err), 32'd1);

        // Malformed MRS variants become DES with cmd_err
        do_reset(1'b0);
        step(1'b0, 1'b1, 1'b0, {1'b1, 3'd1, 18'h00008}, 1'b0);
        check("bad_rsv_cmd_err", 32'(cmd_err), 32'd1);
        check("bad_rsv_no_write", 32'(dut.u_shadow.mr[1]), 32'd0);
        do_reset(1'b0);
        step(1'b0, 1'b1, 1'b0, {1'b0, 3'd7, 18'h00008}, 1'b0);
        check("bad_mr7_cmd_err", 32'(cmd_err), 32'd1);
        do_reset(1'b0);
        step(1'b0, 1'b1, 1'b0, {1'b0, 3'd2, 18'h08008}, 1'b0);
        check("bad_op_cmd_err", 32'(cmd_err), 32'd1);
        check("bad_op_no_write", 32'(dut.u_shadow.mr[2]), 32'd0);

        // MR5 never written
        do_reset(1'b0);
        full_seq(5, 18'h00018);
        check("miss_cfg_err", 32'(cfg_err), 32'd1);
        check("miss_cfg_valid", 32'(cfg_valid), 32'd1);
        check("miss_cmd_terr", {30'h0, cmd_err, timing_err}, 32'd0);

        // Reset mid-sequence, strobe in reset cycle ignored, then new sequence
        do_reset(1'b0);
        mrs(3'd2, 18'h00018);
        check("mid_mr2_written", 32'(dut.u_shadow.mr[2]), 32'h18);
        do_reset(1'b1);
        check("mid_mr2_cleared", 32'(dut.u_shadow.mr[2]), 32'd0);
        check("mid_errs", {29'h0, cmd_err, timing_err, cfg_err}, 32'd0);
        full_seq(-1, 18'h00028);
        check("mid_mr2_new", 32'(dut.u_shadow.mr[2]), 32'h28);
        check("mid_cwl", 32'(cfg_cwl), 32'h5);
        check("mid_final_errs", {29'h0, cmd_err, timing_err, cfg_err}, 32'd0);
        check("mid_cfg_valid", 32'(cfg_valid), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_encoder.md
CMD_ENCODER -- requirements
Module: cmd_encoder

Interface
REQ-001 Parameters: none; tMRD, tMOD come from ddr_pkg.
REQ-002 CK_t  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 des_rdy / mrs_rdy / zqcl_rdy  in  1 each  single-cycle command strobes from the init controller.
REQ-005 mode_reg  in  22  [21] reserved (0), [20:18] MR address {BG0,BA1,BA0}, [17:0] opcode for A[17:0]; valid when mrs_rdy=1.
REQ-006 ini_done  in  1  level; initialization sequence complete.
REQ-007 cs_n, act_n  out  1 each  DDR4 chip select and activate command pins.
REQ-008 bg  out  2  bank group; ba  out  2  bank address.
REQ-009 addr  out  18  A[17:0]; addr[16:14] carry RAS_n/CAS_n/WE_n.
REQ-010 cfg_cl  out  4  {MR0[6:4],MR0[2]}; cfg_bl  out  2  MR0[1:0]; cfg_al  out  2  MR1[4:3]; cfg_cwl  out  3  MR2[5:3].
REQ-011 cfg_tccd  out  3  MR6[12:10]; cfg_wr_pre  out  1  MR4[12]; cfg_rd_pre  out  1  MR4[11].
REQ-012 cfg_valid  out  1  shadowed configuration is complete and frozen.
REQ-013 cmd_err, timing_err, cfg_err  out  1 each  sticky error flags.

Function
REQ-014 All pin outputs SHALL be registered, with exactly one cycle of latency from strobe to pins.
REQ-015 Idle (no strobe) and des_rdy SHALL drive DES: cs_n=1, act_n=1, addr[16:14]=3'b111, bg=0, ba=0, other addr bits 0.
REQ-016 mrs_rdy SHALL drive MRS: cs_n=0, act_n=1, addr[16:14]=3'b000, bg={1'b0,mode_reg[20]}, ba=mode_reg[19:18], addr[17]=mode_reg[17], addr[13:0]=mode_reg[13:0].
REQ-017 zqcl_rdy SHALL drive ZQCL: cs_n=0, act_n=1, addr[16:14]=3'b110, addr[10]=1, all other addr, bg and ba 0.
REQ-018 More than one strobe in the same cycle SHALL set cmd_err; the issued command follows priority mrs > zqcl > des.
REQ-019 MRS with mode_reg[16:14]!=0, mode_reg[21]=1 or MR address 7 SHALL set cmd_err and drive DES instead.
REQ-020 Each accepted MRS SHALL write opcode[17:0] into shadow register MR0..MR6 selected by the address and set that register's written bit.
REQ-021 A gap counter SHALL count cycles since the last issued MRS, saturating at tMOD.
REQ-022 An MRS issued with a gap < tMRD SHALL set timing_err; the command is still issued.
REQ-023 A ZQCL issued with a gap < tMOD SHALL set timing_err; the command is still issued.
REQ-024 FSM states: INIT (reset state) and DONE.
REQ-025 INIT->DONE SHALL occur on the first cycle with ini_done=1; cfg_valid SHALL assert in the same cycle as the DONE entry.
REQ-026 DONE->INIT SHALL occur only on reset.
REQ-027 On INIT->DONE, if any of MR0..MR6 has not been written, cfg_err SHALL be set; cfg_valid asserts regardless.
REQ-028 Any strobe in DONE SHALL set cmd_err and drive DES; shadow registers are frozen.
REQ-029 cfg_* outputs SHALL reflect shadow registers continuously; they are meaningful only while cfg_valid=1.

Reset
REQ-030 reset=1 SHALL force DES on the pins, clear all shadow registers, written bits and errors, set the gap counter to tMOD, cfg_valid=0 and state INIT on the next edge.
REQ-031 Reset asserted mid-sequence SHALL discard partial configuration; strobes in the reset cycle are ignored.

Structure
REQ-032 The DDR4 command encoding enum (DES, MRS, ZQCL) and cmd-bit constants SHALL go in ddr_pkg; tMRD and tMOD are reused from it.
REQ-033 One sub-module SHALL be used: mr_shadow (seven 18-bit registers, write-enable decode, written bits).

Verification
REQ-034 MRS with mode_reg=22'h0C0000 -> next cycle cs_n=0, act_n=1, addr[16:14]=000, bg=00, ba=11; MR3 shadow=0.
REQ-035 Full MR3,6,5,4,2,1,0 sequence spaced tMRD+1, then ZQCL after tMOD, then ini_done -> no errors, cfg_valid=1, cfg_bl/cl/al/cwl equal the programmed fields.
REQ-036 Two MRS 2 cycles apart (tMRD>2) -> timing_err=1; both MRS appear on the pins.
REQ-037 mrs_rdy and zqcl_rdy in the same cycle -> cmd_err=1; MRS is issued.
REQ-038 ini_done with MR5 never written -> cfg_err=1, cfg_valid=1.
REQ-039 Reset after MR2 is written, then the full sequence -> shadow MR2 is first 0, then the new value; no stale errors.
